// File: rtl/mac_ctrl_pkg.sv
// Shared types and defaults for the MAC sequencer.
// Build with MAC_SAT_EN defined for a saturating accumulator and a sticky sat flag.
package mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int N_DEF  = 8;
  localparam int M_DEF  = N_DEF;
  localparam int L_DEF  = 64;
  localparam int CW_DEF = 16;

`ifdef MAC_SAT_EN
  // Low w bits hold the clamp value: -2^(w-1) if neg, else 2^(w-1)-1.
  function automatic logic [127:0] sat_bound(
    input int unsigned w,
    input logic        neg
  );
    logic [127:0] m;
    m = 128'd1 << (w - 1);
    return neg ? m : (m - 128'd1);
  endfunction
`endif

endpackage

// File: rtl/mac_acc.sv
// Signed multiplier feeding an L-bit accumulator with sync clear/enable.
// MAC_SAT_EN selects saturating accumulate plus a sticky sat flag.
module mac_acc #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int L = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] g,
  input  logic [M-1:0] e,
`ifdef MAC_SAT_EN
  output logic         sat,
`endif
  output logic [L-1:0] acc
);

  logic signed [N+M-1:0] prod;
  logic signed [L-1:0]   ext;
  logic signed [L-1:0]   sum;
  logic        [L-1:0]   nxt;

  assign prod = $signed(g) * $signed(e);
  assign ext  = prod;
  assign sum  = $signed(acc) + ext;

`ifdef MAC_SAT_EN
  logic ovf;

  // Same-sign operands producing an opposite-sign sum overflowed.
  assign ovf = (acc[L-1] == ext[L-1]) && (sum[L-1] != acc[L-1]);
  assign nxt = ovf ? L'(mac_ctrl_pkg::sat_bound(L, acc[L-1])) : sum;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= nxt;
      sat <= sat | ovf;
    end
  end
`else
  assign nxt = sum;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= nxt;
    end
  end
`endif

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: takes a job of len operand pairs, streams them
// through mac_acc and hands the result out. MAC_SAT_EN adds the sat port.
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = N,
  parameter int L  = L_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  g_input,
  input  logic [M-1:0]  e_input,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [L-1:0]  o,
`ifdef MAC_SAT_EN
  output logic          sat,
`endif
  output logic [CW-1:0] beat_cnt
);

  if (L < N + M) begin : g_width_chk
    $error("mac_seq_ctrl: L must be >= N+M");
  end

  state_t        state;
  logic [CW-1:0] len_q;
  logic          beat;
  logic          clr;

  assign beat = in_valid && in_ready;
  assign clr  = (state == IDLE) && start;

  mac_acc #(
    .N(N),
    .M(M),
    .L(L)
  ) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (beat),
    .g   (g_input),
    .e   (e_input),
`ifdef MAC_SAT_EN
    .sat (sat),
`endif
    .acc (o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
      len_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            beat_cnt <= '0;
            len_q    <= len;
            busy     <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == len_q - 1'b1) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl at N=M=8, L=16.
// Directed literal checks plus randomized traffic against a job-level model.
module tb_mac_seq_ctrl;

  localparam int N  = 8;
  localparam int M  = 8;
  localparam int L  = 16;
  localparam int CW = 16;
  localparam longint MAXV = (longint'(1) <<< (L - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (L - 1));

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  g_input;
  logic [M-1:0]  e_input;
  logic          out_valid;
  logic          out_ready;
  logic [L-1:0]  o;
  logic [CW-1:0] beat_cnt;
`ifdef MAC_SAT_EN
  logic          sat;
`endif

  mac_seq_ctrl #(
    .N(N),
    .M(M),
    .L(L),
    .CW(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_input   (g_input),
    .e_input   (e_input),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
`ifdef MAC_SAT_EN
    .sat       (sat),
`endif
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: phase 0 waits for a job, 1 collects pairs, 2 holds result.
  int                  phase = 0;
  int                  need = 0;
  int                  m_cnt = 0;
  logic signed [L-1:0] m_acc = '0;
  bit                  m_sat = 1'b0;

  always @(posedge clk) begin
    longint s;
    if (rst) begin
      phase = 0;
      m_cnt = 0;
      m_acc = '0;
      m_sat = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        m_acc = '0;
        m_cnt = 0;
        m_sat = 1'b0;
        need  = int'(len);
        phase = (need == 0) ? 2 : 1;
      end
    end else if (phase == 1) begin
      if (in_valid) begin
        s = longint'(m_acc) +
            longint'($signed(g_input)) * longint'($signed(e_input));
`ifdef MAC_SAT_EN
        if (s > MAXV) begin
          s = MAXV;
          m_sat = 1'b1;
        end else if (s < MINV) begin
          s = MINV;
          m_sat = 1'b1;
        end
`endif
        m_acc = s[L-1:0];
        m_cnt++;
        if (m_cnt == need) phase = 2;
      end
    end else begin
      if (out_ready) phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", busy, phase != 0);
      cmp("in_ready", in_ready, phase == 1);
      cmp("out_valid", out_valid, phase == 2);
      cmp("o", $signed(o), m_acc);
      cmp("beat_cnt", beat_cnt, m_cnt);
`ifdef MAC_SAT_EN
      cmp("sat", sat, m_sat);
`endif
    end
  end

  task automatic start_job(input int n);
    start = 1'b1;
    len   = CW'(n);
    @(negedge clk);
    start = 1'b0;
    len   = CW'($urandom);
  endtask

  task automatic beat(input int a, input int b);
    in_valid = 1'b1;
    g_input  = N'(a);
    e_input  = M'(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    g_input = '0;
    e_input = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    cmp("rst_busy", busy, 0);
    cmp("rst_in_ready", in_ready, 0);
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_o", $signed(o), 0);
    cmp("rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;

    start_job(3);
    beat(2, 3);
    beat(-4, 5);
    beat(7, -1);
    cmp("len3_valid", out_valid, 1);
    cmp("len3_o", $signed(o), -21);
    cmp("len3_cnt", beat_cnt, 3);
    drain();
    cmp("len3_idle", busy, 0);
    cmp("len3_hold_o", $signed(o), -21);

    start_job(4);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      g_input = 8'd1;
      e_input = 8'd1;
      @(negedge clk);
      if (i == 5) begin
        cmp("stall_cnt", beat_cnt, 3);
        cmp("stall_valid", out_valid, 0);
      end
    end
    in_valid = 1'b0;
    cmp("len4_o", $signed(o), 4);
    cmp("len4_valid", out_valid, 1);

    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len = 16'd7;
      @(negedge clk);
    end
    start = 1'b0;
    cmp("bp_valid", out_valid, 1);
    cmp("bp_o", $signed(o), 4);
    drain();
    cmp("bp_idle", busy, 0);

    start_job(0);
    cmp("len0_valid", out_valid, 1);
    cmp("len0_o", $signed(o), 0);
    cmp("len0_in_ready", in_ready, 0);
    drain();

    start_job(5);
    beat(1, 2);
    beat(3, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_busy", busy, 0);
    cmp("abort_valid", out_valid, 0);
    cmp("abort_o", $signed(o), 0);
    cmp("abort_cnt", beat_cnt, 0);
    start_job(1);
    beat(-128, -128);
    cmp("neg_o", $signed(o), 16384);
    drain();

    start_job(3);
    beat(127, 127);
    beat(127, 127);
    beat(127, 127);
`ifdef MAC_SAT_EN
    cmp("ovf_o", $signed(o), 32767);
    cmp("ovf_sat", sat, 1);
`else
    cmp("ovf_o", $signed(o), -17149);
`endif
    drain();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 97 == 0);
      start = ($urandom % 3 == 0);
      len = ($urandom % 8 == 0) ? CW'(20) : CW'($urandom % 7);
      in_valid = ($urandom % 4 != 0);
      g_input = N'($urandom);
      e_input = M'($urandom);
      out_ready = ($urandom % 2 == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
